// File: rtl/delay_pkg.sv
// Shared widths, command address map and ramp FSM states for the delay
// control path.
package delay_pkg;

    localparam int         DEF_BLEND_B = 4;
    localparam int         DEF_DLY_B   = 14;
    localparam int         DEF_FDB_B   = 10;
    // Largest feedback value that keeps the echo loop gain below unity.
    localparam logic [9:0] DEF_FDB_MAX = 10'd960;

    typedef enum logic [1:0] {
        ADDR_BLEND  = 2'd0,
        ADDR_DELAY  = 2'd1,
        ADDR_FEEDBK = 2'd2,
        ADDR_RSVD   = 2'd3
    } cmd_addr_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RAMP = 1'b1
    } ramp_st_t;

endpackage

// File: rtl/delay_slew.sv
// Delay tap slew limiter: holds the requested target and walks the live
// delay toward it by at most SLEW_STEP per sample strobe, so tap changes
// do not produce audible clicks. busy is high while a ramp is running.
module delay_slew
    import delay_pkg::*;
#(
    parameter int               DLY_B     = DEF_DLY_B,
    parameter int               SLEW_STEP = 1,
    parameter logic [DLY_B-1:0] DLY_RST   = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             sample_en,
    input  logic             tgt_we,
    input  logic [DLY_B-1:0] tgt_in,
    output logic [DLY_B-1:0] delay,
    output logic             busy
);

    localparam logic [DLY_B:0] STEP = (DLY_B+1)'(SLEW_STEP);

    ramp_st_t         state, state_nxt;
    logic [DLY_B-1:0] target;
    logic             up;
    logic [DLY_B:0]   diff, step, dly_moved;
    logic [DLY_B-1:0] dly_step;
    logic             unused_carry;

    // Distance to target, clipped step, and the stepped delay. The extra
    // bit keeps the subtraction unsigned without wrap; the result always
    // lands between delay and target, so the carry bit is never set.
    always_comb begin
        up        = target > delay;
        diff      = up ? ({1'b0, target} - {1'b0, delay})
                       : ({1'b0, delay} - {1'b0, target});
        step      = (diff < STEP) ? diff : STEP;
        dly_moved = up ? ({1'b0, delay} + step) : ({1'b0, delay} - step);
    end

    assign {unused_carry, dly_step} = dly_moved;

    // Next state: start a ramp whenever target and delay differ, finish
    // on the strobe that lands exactly on the target.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (target != delay) state_nxt = ST_RAMP;
            ST_RAMP: if (sample_en && dly_step == target) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State, target and live delay registers; delay only moves on strobes
    // while ramping. A new target mid-ramp is simply picked up next step.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= ST_IDLE;
            target <= DLY_RST;
            delay  <= DLY_RST;
        end else begin
            state <= state_nxt;
            if (tgt_we) target <= tgt_in;
            if (state == ST_RAMP && sample_en) delay <= dly_step;
        end
    end

    assign busy = (state == ST_RAMP);

endmodule

// File: rtl/delay_ctrl.sv
// Control-side initiator for the delay effect. Takes register writes from
// the panel/MCU decoder, applies blend and feedback on the audio sample
// strobe, and drives the delay tap.
// Build option DELAY_CTRL_SLEW_EN: when defined the delay tap is slewed by
// delay_slew; otherwise it jumps to the target on the next sample strobe
// and busy is held low.
module delay_ctrl
    import delay_pkg::*;
#(
    parameter int               BLEND_B   = DEF_BLEND_B,
    parameter int               DLY_B     = DEF_DLY_B,
    parameter int               FDB_B     = DEF_FDB_B,
    parameter int               SLEW_STEP = 1,
    parameter logic [FDB_B-1:0] FDB_MAX   = FDB_B'(DEF_FDB_MAX),
    parameter logic [DLY_B-1:0] DLY_RST   = '0
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               sample_en,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_addr,
    input  logic [15:0]        cmd_data,
    output logic [BLEND_B-1:0] blend,
    output logic [DLY_B-1:0]   delay,
    output logic [FDB_B-1:0]   feedbk,
    output logic               busy
);

    cmd_addr_t          addr;
    logic               xfer;
    logic [BLEND_B-1:0] blend_sh;
    logic [FDB_B-1:0]   fdb_sh, fdb_in, fdb_clamped;
    logic               blend_pend, fdb_pend;
    logic               tgt_we;
    logic               unused_data;

    assign addr        = cmd_addr_t'(cmd_addr);
    assign xfer        = cmd_valid & cmd_ready;
    assign tgt_we      = xfer && (addr == ADDR_DELAY);
    assign fdb_in      = cmd_data[FDB_B-1:0];
    // Clamp at write time so the shadow never holds an unstable gain.
    assign fdb_clamped = (fdb_in > FDB_MAX) ? FDB_MAX : fdb_in;
    // Stall further commands until pending shadows have been applied.
    assign cmd_ready   = ~(blend_pend | fdb_pend);
    // Upper data bits are dropped by design.
    assign unused_data = ^cmd_data;

    // Shadow/apply: a strobe applies what was pending before the edge; a
    // write on the same edge only loads the shadow and waits for the next.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blend      <= '0;
            feedbk     <= '0;
            blend_sh   <= '0;
            fdb_sh     <= '0;
            blend_pend <= 1'b0;
            fdb_pend   <= 1'b0;
        end else begin
            if (sample_en) begin
                if (blend_pend) blend  <= blend_sh;
                if (fdb_pend)   feedbk <= fdb_sh;
                blend_pend <= 1'b0;
                fdb_pend   <= 1'b0;
            end
            if (xfer && addr == ADDR_BLEND) begin
                blend_sh   <= cmd_data[BLEND_B-1:0];
                blend_pend <= 1'b1;
            end
            if (xfer && addr == ADDR_FEEDBK) begin
                fdb_sh   <= fdb_clamped;
                fdb_pend <= 1'b1;
            end
        end
    end

`ifdef DELAY_CTRL_SLEW_EN
    delay_slew #(
        .DLY_B     (DLY_B),
        .SLEW_STEP (SLEW_STEP),
        .DLY_RST   (DLY_RST)
    ) u_slew (
        .clk       (clk),
        .reset_n   (reset_n),
        .sample_en (sample_en),
        .tgt_we    (tgt_we),
        .tgt_in    (cmd_data[DLY_B-1:0]),
        .delay     (delay),
        .busy      (busy)
    );
`else
    logic [DLY_B-1:0] target;
    logic             unused_slew;

    assign unused_slew = (SLEW_STEP != 0);
    assign busy        = 1'b0;

    // Unslewed tap: the target lands on the first strobe after the write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            target <= DLY_RST;
            delay  <= DLY_RST;
        end else begin
            if (tgt_we)    target <= cmd_data[DLY_B-1:0];
            if (sample_en) delay  <= target;
        end
    end
`endif

endmodule

// File: tb/tb_delay_ctrl.sv
// Self-checking bench for delay_ctrl: table of handshake/apply vectors,
// hand sequences for ramp, retarget and asynchronous reset, then random
// traffic against a behavioural model.
module tb_delay_ctrl;

    localparam int BLEND_B   = 4;
    localparam int DLY_B     = 14;
    localparam int FDB_B     = 10;
    localparam int SLEW_STEP = 1;
    localparam int FDB_MAX   = 960;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic               sample_en = 1'b0;
    logic               cmd_valid = 1'b0;
    logic               cmd_ready;
    logic [1:0]         cmd_addr = '0;
    logic [15:0]        cmd_data = '0;
    logic [BLEND_B-1:0] blend;
    logic [DLY_B-1:0]   delay;
    logic [FDB_B-1:0]   feedbk;
    logic               busy;

    int checks = 0;
    int errors = 0;

    delay_ctrl #(
        .BLEND_B   (BLEND_B),
        .DLY_B     (DLY_B),
        .FDB_B     (FDB_B),
        .SLEW_STEP (SLEW_STEP)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .sample_en (sample_en),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_data  (cmd_data),
        .blend     (blend),
        .delay     (delay),
        .feedbk    (feedbk),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Behavioural model state
    int m_blend, m_fdb, m_delay, m_target, sh_blend, sh_fdb;
    bit has_blend, has_fdb, m_busy;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_blend = 0; m_fdb = 0; m_delay = 0; m_target = 0;
        sh_blend = 0; sh_fdb = 0; has_blend = 0; has_fdb = 0; m_busy = 0;
    endtask

    // One clock edge of the register-level behaviour.
    task automatic model_edge(input bit se, input bit v, input int a, input int d);
        bit xfer    = v && !(has_blend || has_fdb);
        int old_tgt = m_target;
        int old_dly = m_delay;
        bit was_busy = m_busy;
        if (se) begin
            if (has_blend) m_blend = sh_blend;
            if (has_fdb)   m_fdb   = sh_fdb;
            has_blend = 0;
            has_fdb   = 0;
        end
`ifdef DELAY_CTRL_SLEW_EN
        if (!was_busy) begin
            m_busy = (old_tgt != old_dly);
        end else if (se) begin
            int dist = (old_tgt > old_dly) ? old_tgt - old_dly : old_dly - old_tgt;
            int s    = (dist < SLEW_STEP) ? dist : SLEW_STEP;
            m_delay = (old_tgt > old_dly) ? old_dly + s : old_dly - s;
            m_busy  = (m_delay != old_tgt);
        end
`else
        if (se) m_delay = old_tgt;
`endif
        if (xfer) begin
            case (a)
                0: begin sh_blend = d % 16; has_blend = 1; end
                1: m_target = d % 16384;
                2: begin
                    sh_fdb  = ((d % 1024) > FDB_MAX) ? FDB_MAX : (d % 1024);
                    has_fdb = 1;
                end
                default: ;
            endcase
        end
    endtask

    task automatic compare_all(input string tag);
        chk({tag, ".blend"},  int'(blend),     m_blend);
        chk({tag, ".feedbk"}, int'(feedbk),    m_fdb);
        chk({tag, ".delay"},  int'(delay),     m_delay);
        chk({tag, ".busy"},   int'(busy),      int'(m_busy));
        chk({tag, ".ready"},  int'(cmd_ready), int'(!(has_blend || has_fdb)));
    endtask

    // Drive one cycle, clock it, step the model, compare after the edge.
    task automatic cyc(input bit se, input bit v, input int a, input int d);
        sample_en = se;
        cmd_valid = v;
        cmd_addr  = a[1:0];
        cmd_data  = d[15:0];
        @(posedge clk);
        model_edge(se, v, a, d);
        #1;
        sample_en = 1'b0;
        cmd_valid = 1'b0;
        compare_all("cyc");
    endtask

    task automatic strobe();
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0);
    endtask

    typedef struct {
        bit se;
        bit v;
        int a;
        int d;
        int eb;
        int ef;
        bit er;
    } vec_t;

    vec_t tbl[$];

    initial begin
        int n;
        model_reset();
        // Handshake/apply vectors: expected blend/feedbk/ready after the edge.
        tbl.push_back('{0, 1, 0, 5,          0,   0, 0}); // blend write stalls
        tbl.push_back('{0, 1, 2, 1023,       0,   0, 0}); // held off
        tbl.push_back('{1, 0, 0, 0,          5,   0, 1}); // applied, ready back
        tbl.push_back('{0, 1, 2, 1023,       5,   0, 0}); // feedbk over clamp
        tbl.push_back('{0, 0, 0, 0,          5,   0, 0});
        tbl.push_back('{1, 0, 0, 0,          5, 960, 1}); // clamped to 960
        tbl.push_back('{1, 1, 0, 16'hFFF7,   5, 960, 0}); // write on strobe edge
        tbl.push_back('{1, 0, 0, 0,          7, 960, 1}); // applied next strobe
        tbl.push_back('{0, 1, 3, 16'hFFFF,   7, 960, 1}); // reserved: no effect
        tbl.push_back('{1, 0, 0, 0,          7, 960, 1});
        tbl.push_back('{0, 1, 2, 500,        7, 960, 0});
        tbl.push_back('{0, 1, 1, 0,          7, 960, 0}); // delay write held off
        tbl.push_back('{1, 0, 0, 0,          7, 500, 1});
        tbl.push_back('{0, 1, 2, 960,        7, 500, 0}); // clamp boundary
        tbl.push_back('{1, 0, 0, 0,          7, 960, 1});
        tbl.push_back('{0, 1, 2, 961,        7, 960, 0});
        tbl.push_back('{1, 0, 0, 0,          7, 960, 1});
        tbl.push_back('{0, 1, 2, 16'h0405,   7, 960, 0}); // excess bits dropped
        tbl.push_back('{1, 0, 0, 0,          7,   5, 1});
        tbl.push_back('{0, 1, 0, 16'h0013,   7,   5, 0});
        tbl.push_back('{1, 0, 0, 0,          3,   5, 1});

        // Reset state
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst.blend",  int'(blend),     0);
        chk("rst.delay",  int'(delay),     0);
        chk("rst.feedbk", int'(feedbk),    0);
        chk("rst.busy",   int'(busy),      0);
        chk("rst.ready",  int'(cmd_ready), 1);

        // Table vectors
        foreach (tbl[i]) begin
            cyc(tbl[i].se, tbl[i].v, tbl[i].a, tbl[i].d);
            chk($sformatf("tbl%0d.blend", i),  int'(blend),     tbl[i].eb);
            chk($sformatf("tbl%0d.feedbk", i), int'(feedbk),    tbl[i].ef);
            chk($sformatf("tbl%0d.ready", i),  int'(cmd_ready), int'(tbl[i].er));
            chk($sformatf("tbl%0d.delay", i),  int'(delay),     0);
        end

        // Full ramp 0 -> 1000
        cyc(0, 1, 1, 1000);
        cyc(0, 0, 0, 0);
`ifdef DELAY_CTRL_SLEW_EN
        chk("ramp.busy_rise", int'(busy), 1);
        n = 0;
        while (busy && n < 1100) begin
            strobe();
            n++;
        end
        chk("ramp.strobes", n, 1000);
        chk("ramp.delay_end", int'(delay), 1000);
`else
        strobe();
        chk("jump.delay", int'(delay), 1000);
        chk("jump.busy", int'(busy), 0);
`endif

        // Asynchronous reset mid-cycle, mid-ramp, with a pending shadow
        cyc(0, 1, 1, 2000);
        repeat (5) strobe();
        cyc(0, 1, 2, 700);
        #3 reset_n = 1'b0;
        #1;
        chk("arst.blend",  int'(blend),     0);
        chk("arst.delay",  int'(delay),     0);
        chk("arst.feedbk", int'(feedbk),    0);
        chk("arst.busy",   int'(busy),      0);
        chk("arst.ready",  int'(cmd_ready), 1);
        model_reset();
        @(posedge clk);
        #2 reset_n = 1'b1;
        @(posedge clk);
        #1;
        compare_all("arst_rel");

        // Retarget mid-ramp: up toward 1000, reverse at 600 to 500
`ifdef DELAY_CTRL_SLEW_EN
        cyc(0, 1, 1, 1000);
        n = 0;
        while (delay != 600 && n < 700) begin
            strobe();
            n++;
        end
        chk("rtgt.reach600", int'(delay), 600);
        cyc(0, 1, 1, 500);
        chk("rtgt.busy_held", int'(busy), 1);
        n = 0;
        while (busy && n < 200) begin
            strobe();
            n++;
        end
        chk("rtgt.strobes", n, 100);
        chk("rtgt.delay_end", int'(delay), 500);
`else
        cyc(0, 1, 1, 500);
        chk("nslew.before", int'(delay), 0);
        strobe();
        chk("nslew.delay", int'(delay), 500);
        chk("nslew.busy", int'(busy), 0);
`endif

        // Random traffic against the model
        for (int k = 0; k < 3000; k++) begin
            bit rse  = ($urandom % 4) == 0;
            bit rv   = $urandom % 2;
            int ra   = $urandom % 4;
            int rsel = $urandom % 3;
            int rd;
            if (rsel == 0)      rd = int'($urandom % 65536);
            else if (rsel == 1) rd = (m_delay + int'($urandom % 8)) % 16384;
            else                rd = m_delay;
            cyc(rse, rv, ra, rd);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/delay_ctrl.md
Name: delay_ctrl

Overview:
Control-side initiator for the delay effect; drives its blend/delay/feedbk control inputs.
- Accepts register writes over a valid/ready command port.
- Applies blend and feedbk sample-aligned (on the audio sample strobe).
- Slews the delay tap toward its target at a bounded rate, so delay changes (e.g. 1000 -> 500) do not click.
- Sits between the panel/MCU register decoder and the delay block.

Parameters:
BLEND_B, 4, blend control width
DLY_B, 14, delay tap width (samples)
FDB_B, 10, feedback control width
SLEW_STEP, 1, max delay change per sample strobe (1..2^DLY_B-1)
FDB_MAX, 10'd960, feedback clamp (keeps loop gain < 1)
DLY_RST, 0, delay value after reset

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
sample_en  in  1  one-cycle strobe per audio sample
cmd_valid  in  1  command valid
cmd_ready  out  1  command ready
cmd_addr  in  2  0=blend, 1=delay, 2=feedbk, 3=reserved (write ignored, still handshaken)
cmd_data  in  16  write data, LSB-aligned, excess bits dropped
blend  out  BLEND_B  to delay.blend
delay  out  DLY_B  to delay.delay
feedbk  out  FDB_B  to delay.feedbk
busy  out  1  delay ramp in progress

Behaviour:
Reset (asynchronous, reset_n=0):
- blend=0, delay=DLY_RST, feedbk=0, busy=0, cmd_ready=1.
- All shadow registers cleared and target=DLY_RST.
- Reset mid-ramp abandons the ramp immediately.

Handshake:
- A transfer occurs on a rising clk edge with cmd_valid & cmd_ready.
- Writes to addr 0/2 load a shadow register and set a pending flag.
- cmd_ready=0 while any pending flag is set. It returns to 1 the cycle after the sample_en that applies the shadow.
- Writes to addr 1 never deassert cmd_ready; they load the delay target.
- Write on the same edge as sample_en: the write lands in the shadow, and application waits for the next sample_en (no same-cycle bypass).
- feedbk shadow = min(cmd_data[FDB_B-1:0], FDB_MAX), clamped at write.

Apply: on sample_en, every pending shadow is copied to its output and its flag is cleared. Outputs change only on sample_en edges.

Ramp FSM (states IDLE, RAMP):
- IDLE: if target != delay -> RAMP, busy=1 (registered, the cycle after the target write).
- RAMP, on each sample_en: delay moves toward target by min(SLEW_STEP, |target-delay|), unsigned compare, no wrap.
- RAMP: when delay == target after an update -> IDLE, busy=0 on the same edge.
- A new target during RAMP retargets in place. Direction may reverse; no return to IDLE in between.
- Target equal to current delay while in IDLE: no state change, busy stays 0.
- Arithmetic is done in DLY_B+1 bits. Results never exceed 2^DLY_B-1 and never go below 0.

Latency:
- Command to output = 1 to N clocks, where N is the distance to the next sample_en.
- Full delay ramp = ceil(|delta| / SLEW_STEP) sample strobes.

Optional Feature:
DELAY_CTRL_SLEW_EN
- Defined: ramp behaviour as above.
- Undefined: delay loads the target on the first sample_en after the write. busy is tied 0, the FSM is removed, and SLEW_STEP is unused.

Decomposition:
- Package delay_pkg:
  - default widths BLEND_B/DLY_B/FDB_B
  - typedef enum logic[1:0] cmd_addr_t {ADDR_BLEND, ADDR_DELAY, ADDR_FEEDBK, ADDR_RSVD}
  - typedef enum logic {ST_IDLE, ST_RAMP}
  - FDB_MAX default
- Sub-module delay_slew: target/current registers, step arithmetic, ramp FSM, busy. Instantiated only under DELAY_CTRL_SLEW_EN.

Test Plan:
- Reset checks:
  - Release reset -> blend=0, delay=0, feedbk=0, busy=0, cmd_ready=1.
  - Assert reset_n=0 mid-clock-cycle -> all outputs return to reset values without waiting for a clk edge.
- Delay ramp: write delay=1000, sample_en every 50 clk, SLEW_STEP=1 -> delay increments by 1 per strobe. busy=1 throughout and falls on the 1000th strobe with delay=1000.
- Retarget: at delay=600 mid-ramp, write delay=500 -> delay decrements 600->500 over 100 strobes, then busy=0.
- Feedback clamp and stall:
  - Write feedbk=1023 -> feedbk=960 after next sample_en.
  - cmd_ready=0 from the write until the cycle after that strobe.
  - A second cmd_valid is held off during that window.
- Simultaneous events: write blend=5 on the sample_en edge -> blend unchanged there, becomes 5 at the following sample_en.
- Slew disabled: without DELAY_CTRL_SLEW_EN, write delay=500 -> delay=500 after one sample_en, busy never 1.
